clock_timekeeper: RTL and testbench
===================================

# clock_timekeeper

Real-time 12-hour BCD timekeeper directly upstream of the ST7066 LCD driver.
- Divides the system clock to a 1 Hz tick and keeps hours, minutes, seconds and AM/PM.
- Provides a set mode in which the debounced button pulses select and adjust fields.
- Outputs the time and the per-second pulse consumed by the driver's update-pulse logic.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency; prescaler terminal count is CLK_HZ-1.

Ports:
- i_clk  in  1  system clock; one clock domain, every register on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_ena  in  1  global enable; low freezes every register, including the prescaler.
- i_wr  in  1  set mode; high pauses timekeeping and enables adjustment.
- i_input_pulse  in  1  single-cycle pulse that advances the selected field.
- i_inc_pulse  in  1  single-cycle pulse that increments the selected field.
- i_dec_pulse  in  1  single-cycle pulse that decrements the selected field.
- o_clock_pulse  out  1  single-cycle pulse, once per second of run time.
- o_hh  out  8  hours as two BCD digits, 0x01..0x12.
- o_mm  out  8  minutes as two BCD digits, 0x00..0x59.
- o_ss  out  8  seconds as two BCD digits, 0x00..0x59.
- o_pm  out  1  1 = PM.
- o_sel  out  2  selected field: 0 = hours, 1 = minutes, 2 = seconds.

## Operation
- Reset values: o_hh = 0x12, o_mm = 0x00, o_ss = 0x00, o_pm = 0, o_sel = 0, o_clock_pulse = 0, prescaler = 0.
- i_ena low has priority below reset:
  - All state holds and all input pulses are ignored.
  - o_clock_pulse is driven 0.
- Run mode (i_wr = 0):
  - The prescaler counts 0..CLK_HZ-1.
  - At terminal count the prescaler returns to 0 and the time advances one second.
  - Seconds 0x59 wraps to 0x00 and carries into minutes.
  - Minutes 0x59 wraps to 0x00 and carries into hours.
  - Hours step 0x11→0x12 toggles o_pm.
  - Hours step 0x12→0x01 does not toggle o_pm.
  - Every other hour step is +1 in BCD.
  - inc, dec and input pulses are ignored. o_sel holds.
- Set mode (i_wr = 1):
  - The prescaler is held at 0 and o_clock_pulse stays 0.
  - i_input_pulse steps o_sel 0→1→2→0.
  - i_inc_pulse steps the selected field +1 with wrap and no carry into other fields.
    - Seconds and minutes: 0x59→0x00.
    - Hours: 0x12→0x01, and 0x11→0x12 toggles o_pm.
  - i_dec_pulse steps the selected field −1 with wrap and no borrow.
    - Seconds and minutes: 0x00→0x59.
    - Hours: 0x01→0x12, and 0x12→0x11 toggles o_pm.
- Simultaneous events:
  - inc and dec in the same cycle: both are ignored.
  - inc or dec together with input_pulse: the adjustment applies to the current field, and o_sel advances on the same edge.
- Rising edge of i_wr forces o_sel to 0 on that edge.
- Falling edge of i_wr leaves the prescaler at 0, so the first tick comes a full CLK_HZ cycles after exit.
- All BCD digits are always valid (each nibble 0..9). No illegal value is reachable from reset.

## Timing
- All outputs are registered.
- Tick: on the edge where the prescaler is at CLK_HZ-1, the time registers load the new value and o_clock_pulse rises.
  - During the o_clock_pulse high cycle, o_hh, o_mm, o_ss and o_pm already show the new time.
  - o_clock_pulse is high for exactly one cycle.
  - Tick period is exactly CLK_HZ enabled cycles.
- Adjust latency: a pulse sampled on edge N changes the time or o_sel after edge N, so the new value is visible in cycle N+1.
- Reset mid-count clears the prescaler. The next tick comes CLK_HZ cycles after reset is released.
- i_ena low for k cycles stretches the current second by exactly k cycles.

## Structure
- Shared package holds:
  - field-select encodings SEL_HH, SEL_MM, SEL_SS;
  - reset time constants RST_HH = 0x12, RST_MM = 0x00, RST_SS = 0x00;
  - BCD wrap limits 0x59 and 0x12.
- One sub-module, bcd2_updown:
  - a two-digit BCD register with inc, dec, load, and MIN/MAX parameters;
  - outputs a wrap flag.
  - It is instantiated three times: seconds and minutes with MIN 0x00 / MAX 0x59, hours with MIN 0x01 / MAX 0x12.
- The 11↔12 PM toggle lives in the top level.
- The top level holds the prescaler ($clog2(CLK_HZ) bits), the o_sel counter, and the carry/enable steering.

## Test plan
All scenarios use CLK_HZ = 10.
- Reset, then 10 cycles run mode → o_clock_pulse high exactly at cycle 10, with o_ss = 0x01 in that same cycle; period exactly 10.
- Preset 11:59:59 AM via set mode, then release i_wr → after 10 cycles o_hh = 0x12, o_mm = 0x00, o_ss = 0x00, o_pm = 1. At 12:59:59 PM the next tick → 01:00:00, o_pm = 1.
- Set mode with o_sel = 1 and o_mm = 0x00: one dec → 0x59 with o_hh unchanged; one inc → 0x00.
- Set mode with hours at 0x12 AM: dec → 0x11 with o_pm = 1; inc → 0x12 with o_pm = 0; inc → 0x01.
- inc and dec in the same cycle → no change. inc together with input_pulse while o_sel = 0 → hours +1 and o_sel = 1 in the next cycle.
- i_ena low for 5 cycles mid-second → tick delayed by 5 cycles. Reset asserted at prescaler 7 → outputs return to 12:00:00 AM and the next tick arrives 10 cycles after release.

Source files
------------

// File: rtl/clock_timekeeper_pkg.sv
// Shared encodings and constants for the 12-hour BCD timekeeper.
// Used by the top level, the BCD field counters and the bus interface users.
package clock_timekeeper_pkg;

    typedef enum logic [1:0] {
        SEL_HH = 2'd0,
        SEL_MM = 2'd1,
        SEL_SS = 2'd2
    } sel_e;

    localparam logic [7:0] RST_HH = 8'h12;
    localparam logic [7:0] RST_MM = 8'h00;
    localparam logic [7:0] RST_SS = 8'h00;

    localparam logic [7:0] BCD_MS_MIN = 8'h00;
    localparam logic [7:0] BCD_MS_MAX = 8'h59;
    localparam logic [7:0] BCD_HH_MIN = 8'h01;
    localparam logic [7:0] BCD_HH_MAX = 8'h12;
    localparam logic [7:0] BCD_HH_PM  = 8'h11;

    // Field selection cycles hours -> minutes -> seconds -> hours.
    function automatic sel_e next_sel(input sel_e s);
        case (s)
            SEL_HH:  return SEL_MM;
            SEL_MM:  return SEL_SS;
            default: return SEL_HH;
        endcase
    endfunction

endpackage

// File: rtl/clock_timekeeper_if.sv
// Control inputs and time outputs of the timekeeper, grouped as one bus.
// The master side drives the enables and button pulses; the slave is the timekeeper.
interface clock_timekeeper_if;

    logic       i_ena;
    logic       i_wr;
    logic       i_input_pulse;
    logic       i_inc_pulse;
    logic       i_dec_pulse;
    logic       o_clock_pulse;
    logic [7:0] o_hh;
    logic [7:0] o_mm;
    logic [7:0] o_ss;
    logic       o_pm;
    logic [1:0] o_sel;

    modport master (
        output i_ena, i_wr, i_input_pulse, i_inc_pulse, i_dec_pulse,
        input  o_clock_pulse, o_hh, o_mm, o_ss, o_pm, o_sel
    );

    modport slave (
        input  i_ena, i_wr, i_input_pulse, i_inc_pulse, i_dec_pulse,
        output o_clock_pulse, o_hh, o_mm, o_ss, o_pm, o_sel
    );

endinterface

// File: rtl/clock_timekeeper_bcd2.sv
// Two-digit BCD up/down register wrapping between MIN and MAX.
// wrap_o flags the cycle where an increment or decrement crosses the limit.
module bcd2_updown #(
    parameter logic [7:0] MIN = 8'h00,
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] q_o,
    output logic       wrap_o
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d    = q_q;
        wrap_o = 1'b0;
        if (load_i) begin
            q_d = load_val_i;
        end else if (inc_i && !dec_i) begin
            if (q_q == MAX) begin
                q_d    = MIN;
                wrap_o = 1'b1;
            end else if (q_q[3:0] == 4'd9) begin
                q_d = {q_q[7:4] + 4'd1, 4'd0};
            end else begin
                q_d = {q_q[7:4], q_q[3:0] + 4'd1};
            end
        end else if (dec_i && !inc_i) begin
            if (q_q == MIN) begin
                q_d    = MAX;
                wrap_o = 1'b1;
            end else if (q_q[3:0] == 4'd0) begin
                q_d = {q_q[7:4] - 4'd1, 4'd9};
            end else begin
                q_d = {q_q[7:4], q_q[3:0] - 4'd1};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/clock_timekeeper.sv
// 12-hour BCD real-time clock: 1 Hz prescaler, hh:mm:ss + AM/PM, and a
// set mode where button pulses select and adjust one field at a time.
module clock_timekeeper
    import clock_timekeeper_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    clock_timekeeper_if.slave    bus
);

    localparam int            PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          wr_q, wr_d;
    sel_e          sel_q, sel_d;
    logic          pm_q, pm_d;
    logic          pulse_q, pulse_d;

    logic       run, tick, set_en, adj_inc, adj_dec;
    logic       ss_inc, ss_dec, mm_inc, mm_dec, hh_inc, hh_dec;
    logic       ss_wrap, mm_wrap, hh_wrap_unused;
    logic [7:0] ss, mm, hh;

    assign run     = bus.i_ena && !bus.i_wr;
    assign tick    = run && (presc_q == PRESC_TC);
    assign set_en  = bus.i_ena && bus.i_wr;
    assign adj_inc = set_en && bus.i_inc_pulse && !bus.i_dec_pulse;
    assign adj_dec = set_en && bus.i_dec_pulse && !bus.i_inc_pulse;

    // Carries only ripple on a run-mode tick; set-mode edits never touch neighbours.
    assign ss_inc = tick || (adj_inc && sel_q == SEL_SS);
    assign ss_dec = adj_dec && sel_q == SEL_SS;
    assign mm_inc = (tick && ss_wrap) || (adj_inc && sel_q == SEL_MM);
    assign mm_dec = adj_dec && sel_q == SEL_MM;
    assign hh_inc = (tick && ss_wrap && mm_wrap) || (adj_inc && sel_q == SEL_HH);
    assign hh_dec = adj_dec && sel_q == SEL_HH;

    bcd2_updown #(.MIN(BCD_MS_MIN), .MAX(BCD_MS_MAX)) u_ss (
        .clk_i      (i_clk),
        .load_i     (i_reset),
        .load_val_i (RST_SS),
        .inc_i      (ss_inc),
        .dec_i      (ss_dec),
        .q_o        (ss),
        .wrap_o     (ss_wrap)
    );

    bcd2_updown #(.MIN(BCD_MS_MIN), .MAX(BCD_MS_MAX)) u_mm (
        .clk_i      (i_clk),
        .load_i     (i_reset),
        .load_val_i (RST_MM),
        .inc_i      (mm_inc),
        .dec_i      (mm_dec),
        .q_o        (mm),
        .wrap_o     (mm_wrap)
    );

    bcd2_updown #(.MIN(BCD_HH_MIN), .MAX(BCD_HH_MAX)) u_hh (
        .clk_i      (i_clk),
        .load_i     (i_reset),
        .load_val_i (RST_HH),
        .inc_i      (hh_inc),
        .dec_i      (hh_dec),
        .q_o        (hh),
        .wrap_o     (hh_wrap_unused)
    );

    always_comb begin
        presc_d = presc_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        pm_d    = pm_q;
        pulse_d = 1'b0;
        if (bus.i_ena) begin
            wr_d    = bus.i_wr;
            pulse_d = tick;
            if (bus.i_wr || tick) begin
                presc_d = '0;
            end else begin
                presc_d = presc_q + 1'b1;
            end
            if (bus.i_wr && !wr_q) begin
                sel_d = SEL_HH;
            end else if (bus.i_wr && bus.i_input_pulse) begin
                sel_d = next_sel(sel_q);
            end
            // AM/PM flips across the 11/12 boundary, never across 12/01.
            if ((hh_inc && hh == BCD_HH_PM) || (hh_dec && hh == BCD_HH_MAX)) begin
                pm_d = !pm_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc_q <= '0;
            wr_q    <= 1'b0;
            sel_q   <= SEL_HH;
            pm_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            wr_q    <= wr_d;
            sel_q   <= sel_d;
            pm_q    <= pm_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.o_clock_pulse = pulse_q;
    assign bus.o_hh          = hh;
    assign bus.o_mm          = mm;
    assign bus.o_ss          = ss;
    assign bus.o_pm          = pm_q;
    assign bus.o_sel         = sel_q;

endmodule

// File: tb/tb_clock_timekeeper.sv
// Scoreboard bench for clock_timekeeper at CLK_HZ = 10: stimulus queues expected
// states and ticks, a negedge monitor pops and compares them.
module tb_clock_timekeeper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clock_timekeeper_if bus();

    clock_timekeeper #(.CLK_HZ(10)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      nm;
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       pm;
        logic [1:0] sel;
    } exp_t;

    exp_t st_q[$];
    exp_t tk_q[$];
    int total = 0;
    int bad   = 0;

    task automatic expect_st(input int at, input string nm, input logic [7:0] hh,
                             input logic [7:0] mm, input logic [7:0] ss,
                             input logic pm, input logic [1:0] sel);
        exp_t e;
        e.at = at; e.nm = nm; e.hh = hh; e.mm = mm; e.ss = ss; e.pm = pm; e.sel = sel;
        st_q.push_back(e);
    endtask

    task automatic expect_tick(input int at, input string nm, input logic [7:0] hh,
                               input logic [7:0] mm, input logic [7:0] ss, input logic pm);
        exp_t e;
        e.at = at; e.nm = nm; e.hh = hh; e.mm = mm; e.ss = ss; e.pm = pm; e.sel = 2'd0;
        tk_q.push_back(e);
    endtask

    task automatic drive(input logic inc, input logic dec, input logic inp);
        bus.i_inc_pulse   = inc;
        bus.i_dec_pulse   = dec;
        bus.i_input_pulse = inp;
        @(negedge clk);
        bus.i_inc_pulse   = 1'b0;
        bus.i_dec_pulse   = 1'b0;
        bus.i_input_pulse = 1'b0;
    endtask

    task automatic adj(input logic inc, input logic dec, input logic inp, input string nm,
                       input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss,
                       input logic pm, input logic [1:0] sel);
        expect_st(cyc + 1, nm, hh, mm, ss, pm, sel);
        drive(inc, dec, inp);
    endtask

    // Monitor: state checks at their scheduled cycle, tick checks whenever the pulse is high.
    always @(negedge clk) begin
        exp_t e;
        while (st_q.size() > 0 && st_q[0].at <= cyc) begin
            e = st_q.pop_front();
            total++;
            if (e.at != cyc) begin
                bad++;
                $display("FAIL %s: check due at cycle %0d, monitor at cycle %0d", e.nm, e.at, cyc);
            end else if ({bus.o_hh, bus.o_mm, bus.o_ss, bus.o_pm, bus.o_sel} !==
                         {e.hh, e.mm, e.ss, e.pm, e.sel}) begin
                bad++;
                $display("FAIL %s: got %h:%h:%h pm=%b sel=%0d, want %h:%h:%h pm=%b sel=%0d",
                         e.nm, bus.o_hh, bus.o_mm, bus.o_ss, bus.o_pm, bus.o_sel,
                         e.hh, e.mm, e.ss, e.pm, e.sel);
            end
        end
        if (bus.o_clock_pulse === 1'b1) begin
            total++;
            if (tk_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tick: pulse at cycle %0d, want none", cyc);
            end else begin
                e = tk_q.pop_front();
                if (e.at != cyc || {bus.o_hh, bus.o_mm, bus.o_ss, bus.o_pm} !==
                                   {e.hh, e.mm, e.ss, e.pm}) begin
                    bad++;
                    $display("FAIL %s: got tick cycle %0d %h:%h:%h pm=%b, want cycle %0d %h:%h:%h pm=%b",
                             e.nm, cyc, bus.o_hh, bus.o_mm, bus.o_ss, bus.o_pm,
                             e.at, e.hh, e.mm, e.ss, e.pm);
                end
            end
        end else if (tk_q.size() > 0 && tk_q[0].at <= cyc) begin
            e = tk_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: got no tick by cycle %0d, want tick at cycle %0d", e.nm, cyc, e.at);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, x, y, z, w;
        bus.i_ena         = 1'b1;
        bus.i_wr          = 1'b0;
        bus.i_input_pulse = 1'b0;
        bus.i_inc_pulse   = 1'b0;
        bus.i_dec_pulse   = 1'b0;

        @(negedge clk);
        expect_st(cyc + 1, "reset", 8'h12, 8'h00, 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        expect_st(r + 9, "pre_tick", 8'h12, 8'h00, 8'h00, 1'b0, 2'd0);
        expect_tick(r + 10, "first_tick", 8'h12, 8'h00, 8'h01, 1'b0);
        expect_tick(r + 20, "second_tick", 8'h12, 8'h00, 8'h02, 1'b0);
        repeat (20) @(negedge clk);

        // Set mode: hours around the 11/12 boundary, then preset 11:59:59 AM.
        bus.i_wr = 1'b1;
        expect_st(cyc + 1, "wr_enter", 8'h12, 8'h00, 8'h02, 1'b0, 2'd0);
        @(negedge clk);
        adj(0, 1, 0, "hh_dec_12_11", 8'h11, 8'h00, 8'h02, 1'b1, 2'd0);
        adj(1, 0, 0, "hh_inc_11_12", 8'h12, 8'h00, 8'h02, 1'b0, 2'd0);
        adj(1, 0, 0, "hh_inc_12_01", 8'h01, 8'h00, 8'h02, 1'b0, 2'd0);
        for (int i = 0; i < 9; i++) drive(1, 0, 0);
        adj(1, 0, 0, "hh_inc_to_11", 8'h11, 8'h00, 8'h02, 1'b0, 2'd0);
        adj(1, 1, 0, "inc_dec_same", 8'h11, 8'h00, 8'h02, 1'b0, 2'd0);
        adj(0, 0, 1, "sel_to_mm", 8'h11, 8'h00, 8'h02, 1'b0, 2'd1);
        adj(0, 1, 0, "mm_dec_wrap", 8'h11, 8'h59, 8'h02, 1'b0, 2'd1);
        adj(1, 0, 0, "mm_inc_wrap", 8'h11, 8'h00, 8'h02, 1'b0, 2'd1);
        adj(0, 1, 0, "mm_dec_again", 8'h11, 8'h59, 8'h02, 1'b0, 2'd1);
        adj(0, 0, 1, "sel_to_ss", 8'h11, 8'h59, 8'h02, 1'b0, 2'd2);
        adj(0, 1, 0, "ss_dec_01", 8'h11, 8'h59, 8'h01, 1'b0, 2'd2);
        adj(0, 1, 0, "ss_dec_00", 8'h11, 8'h59, 8'h00, 1'b0, 2'd2);
        adj(0, 1, 0, "ss_dec_wrap", 8'h11, 8'h59, 8'h59, 1'b0, 2'd2);
        adj(1, 0, 0, "ss_inc_wrap", 8'h11, 8'h59, 8'h00, 1'b0, 2'd2);
        adj(0, 1, 0, "ss_dec_back", 8'h11, 8'h59, 8'h59, 1'b0, 2'd2);

        // Run: pulses ignored, then 11:59:59 AM -> 12:00:00 PM.
        bus.i_wr = 1'b0;
        x = cyc;
        expect_tick(x + 10, "tick_am_to_pm", 8'h12, 8'h00, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        adj(1, 0, 1, "run_ignore", 8'h11, 8'h59, 8'h59, 1'b0, 2'd2);
        repeat (7) @(negedge clk);

        // Re-enter set mode: sel forced to hours, then preset 12:59:59 PM.
        y = cyc;
        bus.i_wr = 1'b1;
        expect_st(y + 1, "wr_rise_sel0", 8'h12, 8'h00, 8'h00, 1'b1, 2'd0);
        @(negedge clk);
        adj(1, 0, 1, "inc_with_input", 8'h01, 8'h00, 8'h00, 1'b1, 2'd1);
        adj(0, 1, 0, "mm_dec_pm", 8'h01, 8'h59, 8'h00, 1'b1, 2'd1);
        adj(0, 0, 1, "sel_to_ss_pm", 8'h01, 8'h59, 8'h00, 1'b1, 2'd2);
        adj(0, 1, 0, "ss_dec_pm", 8'h01, 8'h59, 8'h59, 1'b1, 2'd2);
        adj(0, 0, 1, "sel_wrap", 8'h01, 8'h59, 8'h59, 1'b1, 2'd0);
        adj(0, 1, 0, "hh_dec_01_12", 8'h12, 8'h59, 8'h59, 1'b1, 2'd0);
        bus.i_wr = 1'b0;
        z = cyc;
        expect_tick(z + 10, "tick_12_to_01", 8'h01, 8'h00, 8'h00, 1'b1);
        repeat (10) @(negedge clk);

        // Enable low for 5 cycles stretches the second by 5.
        w = cyc;
        expect_tick(w + 15, "tick_ena_stretch", 8'h01, 8'h00, 8'h01, 1'b1);
        repeat (3) @(negedge clk);
        bus.i_ena = 1'b0;
        repeat (5) @(negedge clk);
        bus.i_ena = 1'b1;
        repeat (7) @(negedge clk);

        // Reset with prescaler at 7.
        repeat (7) @(negedge clk);
        rst = 1'b1;
        expect_st(cyc + 1, "reset_mid", 8'h12, 8'h00, 8'h00, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        expect_tick(cyc + 10, "tick_after_reset", 8'h12, 8'h00, 8'h01, 1'b0);
        repeat (12) @(negedge clk);

        total++;
        if (st_q.size() != 0 || tk_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: got %0d state and %0d tick checks pending, want 0",
                     st_q.size(), tk_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
